// File: rtl/burst_slave_mem.sv
// Burst responder: accepts single-request write/read bursts and backs them with
// an internal register-file memory, streaming read beats under ready/valid.
module burst_slave_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_wr,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [LEN_W-1:0]  io_req_len,
    input  logic              io_wdata_valid,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_wdata_ready,
    output logic              io_rdata_valid,
    output logic [DATA_W-1:0] io_rdata,
    input  logic              io_rdata_ready,
    output logic              io_done,
    output logic              io_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_req_fire;
    logic w_last;

    always_comb begin
        // Held reset masks acceptance even though state already reads IDLE.
        io_req_ready   = (r_state == S_IDLE) && !reset;
        io_wdata_ready = (r_state == S_WRITE);
        io_rdata_valid = (r_state == S_READ);
        io_rdata       = (r_state == S_READ) ? r_mem[r_addr] : '0;
        io_done        = (r_state == S_DONE);
        io_err         = (r_state == S_DONE) && r_err;
        w_req_fire     = io_req_valid && io_req_ready;
        w_last         = (r_cnt == LEN_W'(1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_mem   <= '{default: '0};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_addr <= io_req_addr;
                        r_cnt  <= io_req_len;
                        if (io_req_len == '0) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= io_req_wr ? S_WRITE : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (io_wdata_valid) begin
                        r_mem[r_addr] <= io_wdata;
                        r_addr        <= r_addr + ADDR_W'(1);
                        r_cnt         <= r_cnt - LEN_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (io_rdata_ready) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= r_cnt - LEN_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_slave_mem.sv
// Bench for burst_slave_mem: directed scenarios plus randomized bursts checked
// against a word-array memory model with per-cycle handshake expectations.
module tb_burst_slave_mem;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_req_valid;
    logic          io_req_ready;
    logic          io_req_wr;
    logic [AW-1:0] io_req_addr;
    logic [LW-1:0] io_req_len;
    logic          io_wdata_valid;
    logic [DW-1:0] io_wdata;
    logic          io_wdata_ready;
    logic          io_rdata_valid;
    logic [DW-1:0] io_rdata;
    logic          io_rdata_ready;
    logic          io_done;
    logic          io_err;

    always #5 clock = ~clock;

    burst_slave_mem #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .LEN_W (LW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_wr     (io_req_wr),
        .io_req_addr   (io_req_addr),
        .io_req_len    (io_req_len),
        .io_wdata_valid(io_wdata_valid),
        .io_wdata      (io_wdata),
        .io_wdata_ready(io_wdata_ready),
        .io_rdata_valid(io_rdata_valid),
        .io_rdata      (io_rdata),
        .io_rdata_ready(io_rdata_ready),
        .io_done       (io_done),
        .io_err        (io_err)
    );

    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] wbuf  [16];
    logic [DW-1:0] rbuf  [16];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    endtask

    task automatic idle_inputs();
        io_req_valid   = 1'b0;
        io_req_wr      = 1'b0;
        io_req_addr    = '0;
        io_req_len     = '0;
        io_wdata_valid = 1'b0;
        io_wdata       = '0;
        io_rdata_ready = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        idle_inputs();
        repeat (cycles) begin
            @(negedge clock);
            chk("rst_held_req_ready", io_req_ready, 0);
            chk("rst_held_done", io_done, 0);
        end
        reset = 1'b0;
        m_clear();
        @(negedge clock);
        chk("rst_req_ready", io_req_ready, 1);
        chk("rst_wdata_ready", io_wdata_ready, 0);
        chk("rst_rdata_valid", io_rdata_valid, 0);
        chk("rst_rdata", io_rdata, 0);
        chk("rst_done", io_done, 0);
        chk("rst_err", io_err, 0);
    endtask

    task automatic send_req(input bit wr, input logic [3:0] addr, input logic [3:0] len);
        int t = 0;
        while (!io_req_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("req_ready_wait", io_req_ready, 1);
        io_req_valid = 1'b1;
        io_req_wr    = wr;
        io_req_addr  = addr;
        io_req_len   = len;
        @(negedge clock);
        io_req_valid = 1'b0;
        io_req_addr  = $urandom;
        io_req_len   = $urandom;
    endtask

    task automatic expect_done(input bit err, input bit do_cyc, input int cyc, input int exp_cyc);
        io_wdata_valid = 1'b0;
        io_rdata_ready = 1'b0;
        chk("done", io_done, 1);
        chk("done_err", io_err, err);
        if (do_cyc) chk("done_cycles", cyc, exp_cyc);
        chk("done_req_ready", io_req_ready, 0);
        chk("done_wdata_ready", io_wdata_ready, 0);
        chk("done_rdata_valid", io_rdata_valid, 0);
        @(negedge clock);
        chk("post_done_req_ready", io_req_ready, 1);
        chk("post_done_pulse", io_done, 0);
    endtask

    task automatic wr_burst(input logic [3:0] addr, input int len, input int gap_pct,
                            input bit use_pat, input logic [15:0] vpat);
        int         cyc = 2;
        int         beats = 0;
        int         stalls = 0;
        int         k = 0;
        logic [3:0] a = addr;
        bit         v;
        send_req(1'b1, addr, 4'(len));
        if (len == 0) begin
            expect_done(1'b1, 1'b0, 0, 0);
            return;
        end
        while (beats < len && cyc < 200) begin
            chk("wr_wdata_ready", io_wdata_ready, 1);
            chk("wr_req_ready", io_req_ready, 0);
            chk("wr_rdata_valid", io_rdata_valid, 0);
            chk("wr_done", io_done, 0);
            if (use_pat) v = (k < 16) ? vpat[k] : 1'b1;
            else         v = ($urandom_range(99) >= gap_pct);
            k++;
            io_wdata_valid = v;
            io_wdata       = v ? wbuf[beats] : $urandom;
            io_rdata_ready = 1'($urandom_range(1));
            io_req_valid   = 1'($urandom_range(1));
            @(negedge clock);
            cyc++;
            if (v) begin
                m_mem[a] = wbuf[beats];
                a++;
                beats++;
            end else begin
                stalls++;
            end
        end
        io_req_valid = 1'b0;
        chk("wr_beats", beats, len);
        expect_done(1'b0, 1'b1, cyc, len + 2 + stalls);
    endtask

    task automatic rd_burst(input logic [3:0] addr, input int len, input int rdy_pct,
                            input bit use_pat, input logic [15:0] rpat);
        int         cyc = 2;
        int         beats = 0;
        int         stalls = 0;
        int         k = 0;
        logic [3:0] a = addr;
        bit         r;
        send_req(1'b0, addr, 4'(len));
        if (len == 0) begin
            expect_done(1'b1, 1'b0, 0, 0);
            return;
        end
        while (beats < len && cyc < 200) begin
            chk("rd_rdata_valid", io_rdata_valid, 1);
            chk("rd_rdata", io_rdata, m_mem[a]);
            chk("rd_wdata_ready", io_wdata_ready, 0);
            chk("rd_req_ready", io_req_ready, 0);
            chk("rd_done", io_done, 0);
            if (use_pat) r = (k < 16) ? rpat[k] : 1'b1;
            else         r = ($urandom_range(99) < rdy_pct);
            k++;
            io_rdata_ready = r;
            io_wdata_valid = 1'($urandom_range(1));
            io_wdata       = $urandom;
            io_req_valid   = 1'($urandom_range(1));
            if (r) rbuf[beats] = io_rdata;
            @(negedge clock);
            cyc++;
            if (r) begin
                a++;
                beats++;
            end else begin
                stalls++;
            end
        end
        io_req_valid = 1'b0;
        chk("rd_beats", beats, len);
        expect_done(1'b0, 1'b1, cyc, len + 2 + stalls);
    endtask

    task automatic dump_check();
        rd_burst(4'h0, 8, 100, 1'b0, '0);
        rd_burst(4'h8, 8, 70, 1'b0, '0);
    endtask

    initial begin
        idle_inputs();
        m_clear();
        @(negedge clock);
        do_reset(2);

        // Basic write then read back.
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        wr_burst(4'h7, 4, 0, 1'b1, 16'hFFFF);
        rd_burst(4'h7, 4, 100, 1'b1, 16'hFFFF);
        chk("basic_rd0", rbuf[0], 32'hA);
        chk("basic_rd1", rbuf[1], 32'hB);
        chk("basic_rd2", rbuf[2], 32'hC);
        chk("basic_rd3", rbuf[3], 32'hD);

        // Address wrap past 0xF.
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        wr_burst(4'hE, 4, 0, 1'b1, 16'hFFFF);
        rd_burst(4'h0, 2, 100, 1'b1, 16'hFFFF);
        chk("wrap_rd0", rbuf[0], 32'd3);
        chk("wrap_rd1", rbuf[1], 32'd4);
        rd_burst(4'hE, 2, 100, 1'b1, 16'hFFFF);
        chk("wrap_memE", rbuf[0], 32'd1);
        chk("wrap_memF", rbuf[1], 32'd2);

        // Read backpressure: ready 1,0,0,1,0,1.
        rd_burst(4'h7, 3, 0, 1'b1, 16'b101001);
        chk("bp_rd0", rbuf[0], 32'hA);
        chk("bp_rd1", rbuf[1], 32'hB);
        chk("bp_rd2", rbuf[2], 32'hC);

        // Write with valid gaps: 0,1,0,0,1,1.
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33;
        wr_burst(4'h3, 3, 0, 1'b1, 16'b110010);
        rd_burst(4'h3, 3, 100, 1'b1, 16'hFFFF);
        chk("gap_rd0", rbuf[0], 32'h11);
        chk("gap_rd1", rbuf[1], 32'h22);
        chk("gap_rd2", rbuf[2], 32'h33);

        // Zero-length requests leave memory untouched.
        wr_burst(4'h5, 0, 0, 1'b0, '0);
        rd_burst(4'h5, 0, 100, 1'b0, '0);
        dump_check();

        // Reset after two of four write beats.
        send_req(1'b1, 4'h7, 4'd4);
        io_wdata_valid = 1'b1;
        io_wdata       = 32'h55;
        @(negedge clock);
        io_wdata       = 32'h66;
        @(negedge clock);
        do_reset(1);
        chk("abort_done", io_done, 0);
        rd_burst(4'h7, 2, 100, 1'b1, 16'hFFFF);
        chk("abort_rd0", rbuf[0], 32'h0);
        chk("abort_rd1", rbuf[1], 32'h0);

        // Randomized bursts against the model.
        for (int n = 0; n < 80; n++) begin
            int ln;
            ln = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(15, 1));
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            if ($urandom_range(24) == 0) begin
                do_reset(int'($urandom_range(2, 1)));
            end else if ($urandom_range(1) == 1) begin
                wr_burst(4'($urandom), ln, int'($urandom_range(60)), 1'b0, '0);
            end else begin
                rd_burst(4'($urandom), ln, int'($urandom_range(100, 30)), 1'b0, '0);
            end
        end
        dump_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
